// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Provides the sequencer state enum, register index width and PC index.
package pipe_hazard_ctrl_pkg;

   localparam int REG_IDX_W = 4;
   localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_raw_detect.sv
// Combinational RAW / status-register hazard compare for the ID stage.
// Ports: ID source indices/flags, EX and MEM writeback info -> o_hz.
module pipe_raw_detect
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int FWD_EN = 1
) (
   input  logic                 i_id_valid,
   input  logic [REG_IDX_W-1:0] i_id_src1,
   input  logic [REG_IDX_W-1:0] i_id_src2,
   input  logic                 i_id_two_src,
   input  logic                 i_id_uses_sr,
   input  logic                 i_exe_wb_en,
   input  logic [REG_IDX_W-1:0] i_exe_dest,
   input  logic                 i_exe_mem_r_en,
   input  logic                 i_exe_s,
   input  logic                 i_mem_wb_en,
   input  logic [REG_IDX_W-1:0] i_mem_dest,
   output logic                 o_hz
);

   logic w_match_ex;
   logic w_match_mem;
   logic w_raw;

   assign w_match_ex  = (i_exe_dest == i_id_src1) ||
                        (i_id_two_src && (i_exe_dest == i_id_src2));
   assign w_match_mem = (i_mem_dest == i_id_src1) ||
                        (i_id_two_src && (i_mem_dest == i_id_src2));

   // With forwarding only a load result is too late for EX.
   always_comb begin
      w_raw = 1'b0;
      if (FWD_EN != 0) begin
         w_raw = i_exe_mem_r_en && i_exe_wb_en && w_match_ex;
      end else begin
         w_raw = (i_exe_wb_en && w_match_ex) ||
                 (i_mem_wb_en && w_match_mem);
      end
   end

   assign o_hz = i_id_valid && (w_raw || (i_id_uses_sr && i_exe_s));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: freezes on slow memory, flushes on taken
// branch, bubbles ID/EX on hazards; drives stage enables and perf counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int FWD_EN      = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_src1,
   input  logic [REG_IDX_W-1:0] id_src2,
   input  logic                 id_two_src,
   input  logic                 id_uses_sr,
   input  logic                 exe_wb_en,
   input  logic [REG_IDX_W-1:0] exe_dest,
   input  logic                 exe_mem_r_en,
   input  logic                 exe_s,
   input  logic                 mem_wb_en,
   input  logic [REG_IDX_W-1:0] mem_dest,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   input  logic                 branch_taken,
   output logic                 pc_en,
   output logic                 ifid_en,
   output logic                 ifid_flush,
   output logic                 idex_en,
   output logic                 idex_flush,
   output logic                 exmem_en,
   output logic                 memwb_en,
   output logic                 mem_err,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt,
   output logic [CNT_W-1:0]     freeze_cnt
);

   localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WC_W-1:0]  r_wait_cnt;
   logic [WC_W-1:0]  w_wait_nxt;
   logic             r_mem_err;
   logic             w_mem_err_nxt;
   logic             w_freeze;
   logic             w_hz;
   logic             w_sel_off;
   logic             w_sel_br;
   logic             w_sel_hz;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [CNT_W-1:0] r_freeze_cnt;

   pipe_raw_detect #(
      .FWD_EN (FWD_EN)
   ) u_raw (
      .i_id_valid     (id_valid),
      .i_id_src1      (id_src1),
      .i_id_src2      (id_src2),
      .i_id_two_src   (id_two_src),
      .i_id_uses_sr   (id_uses_sr),
      .i_exe_wb_en    (exe_wb_en),
      .i_exe_dest     (exe_dest),
      .i_exe_mem_r_en (exe_mem_r_en),
      .i_exe_s        (exe_s),
      .i_mem_wb_en    (mem_wb_en),
      .i_mem_dest     (mem_dest),
      .o_hz           (w_hz)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_mem_err  <= w_mem_err_nxt;
      end
   end

   // Freeze starts in the same cycle the slow access is seen in RUN.
   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait_cnt;
      w_mem_err_nxt = r_mem_err;
      w_freeze      = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (mem_req && !mem_ready) begin
               w_freeze    = 1'b1;
               w_state_nxt = ST_WAIT;
               w_wait_nxt  = WC_W'(1);
            end
         end
         ST_WAIT: begin
            if (mem_ready) begin
               w_state_nxt = ST_RUN;
               w_wait_nxt  = '0;
            end else begin
               w_freeze = 1'b1;
               if (r_wait_cnt == WC_MAX) begin
                  w_state_nxt   = ST_ERR;
                  w_mem_err_nxt = 1'b1;
               end else begin
                  w_wait_nxt = r_wait_cnt + WC_W'(1);
               end
            end
         end
         ST_ERR: begin
            w_freeze = 1'b1;
         end
         default: begin
            w_freeze    = 1'b1;
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
         end
      endcase
   end

   // Mutually exclusive selects encode the priority order.
   assign w_sel_off = rst || w_freeze;
   assign w_sel_br  = !w_sel_off && branch_taken;
   assign w_sel_hz  = !w_sel_off && !branch_taken && w_hz;

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      unique case (1'b1)
         w_sel_off: begin
            pc_en = 1'b0;
         end
         w_sel_br: begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end
         w_sel_hz: begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end
         default: begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_flush_cnt  <= '0;
         r_freeze_cnt <= '0;
      end else begin
         if (w_sel_hz && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_sel_br && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
         if (w_freeze && (r_freeze_cnt != CNT_MAX)) begin
            r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
         end
      end
   end

   assign mem_err    = r_mem_err && !rst;
   assign stall_cnt  = r_stall_cnt;
   assign flush_cnt  = r_flush_cnt;
   assign freeze_cnt = r_freeze_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: two instances (forwarding and
// non-forwarding, small counters on the latter) against a behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int T    = 8;
   localparam int WB   = 4;
   localparam logic [6:0] C_NORM = 7'b1101011;
   localparam logic [6:0] C_BR   = 7'b1111111;
   localparam logic [6:0] C_HZ   = 7'b0001111;
   localparam logic [6:0] C_OFF  = 7'b0000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic id_valid = 0, id_two_src = 0, id_uses_sr = 0;
   logic [3:0] id_src1 = 0, id_src2 = 0, exe_dest = 0, mem_dest = 0;
   logic exe_wb_en = 0, exe_mem_r_en = 0, exe_s = 0, mem_wb_en = 0;
   logic mem_req = 0, mem_ready = 0, branch_taken = 0;

   logic pc_a, ifen_a, iffl_a, iden_a, idfl_a, exen_a, mwen_a, err_a;
   logic pc_b, ifen_b, iffl_b, iden_b, idfl_b, exen_b, mwen_b, err_b;
   logic [15:0] stall_a, flush_a, freeze_a;
   logic [WB-1:0] stall_b, flush_b, freeze_b;
   logic [6:0] ctrl_a, ctrl_b;

   assign ctrl_a = {pc_a, ifen_a, iffl_a, iden_a, idfl_a, exen_a, mwen_a};
   assign ctrl_b = {pc_b, ifen_b, iffl_b, iden_b, idfl_b, exen_b, mwen_b};

   int checks = 0;
   int errors = 0;

   bit m_busy = 0, m_err = 0;
   int m_run = 0;
   int n_stall_a = 0, n_stall_b = 0, n_flush = 0, n_freeze = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(T), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
      .id_src2(id_src2), .id_two_src(id_two_src), .id_uses_sr(id_uses_sr),
      .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
      .exe_mem_r_en(exe_mem_r_en), .exe_s(exe_s), .mem_wb_en(mem_wb_en),
      .mem_dest(mem_dest), .mem_req(mem_req), .mem_ready(mem_ready),
      .branch_taken(branch_taken), .pc_en(pc_a), .ifid_en(ifen_a),
      .ifid_flush(iffl_a), .idex_en(iden_a), .idex_flush(idfl_a),
      .exmem_en(exen_a), .memwb_en(mwen_a), .mem_err(err_a),
      .stall_cnt(stall_a), .flush_cnt(flush_a), .freeze_cnt(freeze_a));

   pipe_hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(T), .CNT_W(WB)) dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
      .id_src2(id_src2), .id_two_src(id_two_src), .id_uses_sr(id_uses_sr),
      .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
      .exe_mem_r_en(exe_mem_r_en), .exe_s(exe_s), .mem_wb_en(mem_wb_en),
      .mem_dest(mem_dest), .mem_req(mem_req), .mem_ready(mem_ready),
      .branch_taken(branch_taken), .pc_en(pc_b), .ifid_en(ifen_b),
      .ifid_flush(iffl_b), .idex_en(iden_b), .idex_flush(idfl_b),
      .exmem_en(exen_b), .memwb_en(mwen_b), .mem_err(err_b),
      .stall_cnt(stall_b), .flush_cnt(flush_b), .freeze_cnt(freeze_b));

   // ---------------- reference model ----------------
   function automatic bit mt(logic [3:0] d);
      return (d == id_src1) || (id_two_src && d == id_src2);
   endfunction

   function automatic bit hz(bit fwd);
      bit raw;
      if (!id_valid) return 1'b0;
      if (fwd) raw = exe_mem_r_en && exe_wb_en && mt(exe_dest);
      else raw = (exe_wb_en && mt(exe_dest)) || (mem_wb_en && mt(mem_dest));
      return raw || (id_uses_sr && exe_s);
   endfunction

   function automatic bit m_frz();
      return m_err || ((m_busy || mem_req) && !mem_ready);
   endfunction

   function automatic logic [6:0] exp_ctrl(bit fwd);
      if (rst) return C_OFF;
      if (m_frz()) return C_OFF;
      if (branch_taken) return C_BR;
      if (hz(fwd)) return C_HZ;
      return C_NORM;
   endfunction

   function automatic int sat(int n, int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   function automatic logic [47:0] exp_cnt_a();
      return {16'(sat(n_stall_a, 16)), 16'(sat(n_flush, 16)),
              16'(sat(n_freeze, 16))};
   endfunction

   function automatic logic [3*WB-1:0] exp_cnt_b();
      return {WB'(sat(n_stall_b, WB)), WB'(sat(n_flush, WB)),
              WB'(sat(n_freeze, WB))};
   endfunction

   // Advance one clock and update the model with the inputs seen at the edge.
   task automatic tick();
      bit f, b, ha, hb;
      f  = m_frz();
      b  = !f && branch_taken;
      ha = !f && !branch_taken && hz(1'b1);
      hb = !f && !branch_taken && hz(1'b0);
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_err = 0; m_run = 0;
         n_stall_a = 0; n_stall_b = 0; n_flush = 0; n_freeze = 0;
      end else begin
         if (f) n_freeze++;
         if (b) n_flush++;
         if (ha) n_stall_a++;
         if (hb) n_stall_b++;
         if (!m_err) begin
            if ((m_busy || mem_req) && !mem_ready) begin
               m_busy = 1;
               m_run++;
               if (m_run > T) m_err = 1;
            end else begin
               m_busy = 0;
               m_run = 0;
            end
         end
      end
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_two_src = 0; id_uses_sr = 0;
      id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
      exe_wb_en = 0; exe_mem_r_en = 0; exe_s = 0; mem_wb_en = 0;
      mem_req = 0; mem_ready = 0; branch_taken = 0;
   endtask

   task automatic load_use();
      id_valid = 1; id_src1 = 4'd3;
      exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      rst = 1;
      tick();
      #1;
      checks++;
      if (ctrl_a !== C_OFF || ctrl_b !== C_OFF) begin
         errors++;
         $display("FAIL reset_ctrl got %b/%b exp %b", ctrl_a, ctrl_b, C_OFF);
      end
      checks++;
      if (err_a !== 1'b0 || err_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got %b/%b exp 0", err_a, err_b);
      end
      tick();
      rst = 0;
      #1;
      checks++;
      if (ctrl_a !== C_NORM || ctrl_b !== C_NORM) begin
         errors++;
         $display("FAIL post_reset_ctrl got %b/%b exp %b",
                  ctrl_a, ctrl_b, C_NORM);
      end
      checks++;
      if ({stall_a, flush_a, freeze_a} !== 48'd0 ||
          {stall_b, flush_b, freeze_b} !== 12'd0) begin
         errors++;
         $display("FAIL post_reset_cnt got %h/%h exp 0",
                  {stall_a, flush_a, freeze_a}, {stall_b, flush_b, freeze_b});
      end
   endtask

   task automatic test_load_use();
      idle();
      load_use();
      #1;
      checks++;
      if (ctrl_a !== C_HZ) begin
         errors++;
         $display("FAIL load_use_ctrl got %b exp %b", ctrl_a, C_HZ);
      end
      tick();
      idle();
      #1;
      checks++;
      if (ctrl_a !== C_NORM) begin
         errors++;
         $display("FAIL load_use_release got %b exp %b", ctrl_a, C_NORM);
      end
      checks++;
      if (stall_a !== 16'd1) begin
         errors++;
         $display("FAIL load_use_cnt got %0d exp 1", stall_a);
      end
   endtask

   task automatic test_branch_vs_hazard();
      idle();
      load_use();
      branch_taken = 1;
      #1;
      checks++;
      if (ctrl_a !== C_BR || ctrl_b !== C_BR) begin
         errors++;
         $display("FAIL branch_ctrl got %b/%b exp %b", ctrl_a, ctrl_b, C_BR);
      end
      tick();
      idle();
      #1;
      checks++;
      if (flush_a !== 16'd1 || stall_a !== 16'd1) begin
         errors++;
         $display("FAIL branch_cnt got flush=%0d stall=%0d exp 1/1",
                  flush_a, stall_a);
      end
   endtask

   task automatic test_mem_wait();
      int f0;
      idle();
      f0 = n_freeze;
      mem_req = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (ctrl_a !== C_OFF || ctrl_b !== C_OFF) begin
            errors++;
            $display("FAIL mem_wait_freeze%0d got %b/%b exp %b",
                     i, ctrl_a, ctrl_b, C_OFF);
         end
         tick();
      end
      mem_ready = 1;
      #1;
      checks++;
      if (ctrl_a !== C_NORM) begin
         errors++;
         $display("FAIL mem_wait_release got %b exp %b", ctrl_a, C_NORM);
      end
      tick();
      idle();
      #1;
      checks++;
      if (int'(freeze_a) !== f0 + 4 || ctrl_a !== C_NORM) begin
         errors++;
         $display("FAIL mem_wait_cnt got %0d ctrl %b exp %0d ctrl %b",
                  freeze_a, ctrl_a, f0 + 4, C_NORM);
      end
   endtask

   task automatic test_fwd_off();
      idle();
      id_valid = 1; mem_wb_en = 1; mem_dest = 4'd5;
      id_two_src = 1; id_src2 = 4'd5; id_src1 = 4'd1;
      #1;
      checks++;
      if (ctrl_b !== C_HZ || ctrl_a !== C_NORM) begin
         errors++;
         $display("FAIL fwd_off_two got %b/%b exp %b/%b",
                  ctrl_a, ctrl_b, C_NORM, C_HZ);
      end
      tick();
      id_two_src = 0;
      #1;
      checks++;
      if (ctrl_b !== C_NORM) begin
         errors++;
         $display("FAIL fwd_off_one got %b exp %b", ctrl_b, C_NORM);
      end
      tick();
      idle();
   endtask

   task automatic test_saturation();
      idle();
      load_use();
      for (int i = 0; i < 20; i++) tick();
      idle();
      #1;
      checks++;
      if (stall_b !== 4'd15 || int'(stall_a) !== n_stall_a) begin
         errors++;
         $display("FAIL sat_cnt got %0d/%0d exp %0d/15",
                  stall_a, stall_b, n_stall_a);
      end
   endtask

   task automatic test_timeout();
      idle();
      mem_req = 1;
      for (int i = 0; i <= T; i++) begin
         #1;
         checks++;
         if (err_a !== 1'b0 || ctrl_a !== C_OFF) begin
            errors++;
            $display("FAIL timeout_pre%0d got err=%b ctrl=%b exp 0/%b",
                     i, err_a, ctrl_a, C_OFF);
         end
         tick();
      end
      checks++;
      if (err_a !== 1'b1 || err_b !== 1'b1) begin
         errors++;
         $display("FAIL timeout_err got %b/%b exp 1", err_a, err_b);
      end
      mem_req = 0;
      mem_ready = 1;
      tick();
      tick();
      checks++;
      if (ctrl_a !== C_OFF || err_a !== 1'b1) begin
         errors++;
         $display("FAIL timeout_stuck got %b err=%b exp %b err=1",
                  ctrl_a, err_a, C_OFF);
      end
      rst = 1;
      tick();
      rst = 0;
      idle();
      #1;
      checks++;
      if (err_a !== 1'b0 || ctrl_a !== C_NORM) begin
         errors++;
         $display("FAIL timeout_clear got err=%b ctrl=%b exp 0/%b",
                  err_a, ctrl_a, C_NORM);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom_range(0, 99) == 0);
         id_valid     = ($urandom_range(0, 3) != 0);
         id_src1      = 4'($urandom_range(0, 3));
         id_src2      = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) id_src1 = 4'd15;
         id_two_src   = 1'($urandom);
         id_uses_sr   = ($urandom_range(0, 3) == 0);
         exe_wb_en    = 1'($urandom);
         exe_dest     = 4'($urandom_range(0, 3));
         exe_mem_r_en = 1'($urandom);
         exe_s        = ($urandom_range(0, 3) == 0);
         mem_wb_en    = 1'($urandom);
         mem_dest     = 4'($urandom_range(0, 3));
         mem_req      = ($urandom_range(0, 3) == 0);
         mem_ready    = ($urandom_range(0, 2) != 0);
         branch_taken = ($urandom_range(0, 4) == 0);
         #1;
         checks++;
         if (ctrl_a !== exp_ctrl(1'b1) || ctrl_b !== exp_ctrl(1'b0)) begin
            errors++;
            $display("FAIL rand_ctrl%0d got %b/%b exp %b/%b", i,
                     ctrl_a, ctrl_b, exp_ctrl(1'b1), exp_ctrl(1'b0));
         end
         checks++;
         if (err_a !== (m_err && !rst) || err_b !== (m_err && !rst)) begin
            errors++;
            $display("FAIL rand_err%0d got %b/%b exp %b", i,
                     err_a, err_b, m_err && !rst);
         end
         checks++;
         if ({stall_a, flush_a, freeze_a} !== exp_cnt_a() ||
             {stall_b, flush_b, freeze_b} !== exp_cnt_b()) begin
            errors++;
            $display("FAIL rand_cnt%0d got %h/%h exp %h/%h", i,
                     {stall_a, flush_a, freeze_a},
                     {stall_b, flush_b, freeze_b},
                     exp_cnt_a(), exp_cnt_b());
         end
         tick();
      end
      rst = 0;
      idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_vs_hazard();
      test_mem_wait();
      test_fwd_off();
      test_saturation();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
